dmem_line_responder: RTL and testbench

- Responder (slave) end of the 256-bit line-transfer interface driven by the data-cache controller's miss/writeback engine.
- Accepts one line read or line write per request, waits a fixed programmable latency, performs the access on an internal line array, and pulses a one-cycle acknowledge.
- Sits between the dcache and the behavioural main memory. Replaces the testbench memory model with synthesizable, cycle-exact RTL.

---
 rtl/dmem_pkg.sv | 23 ++
 rtl/dmem_line_responder_if.sv | 23 ++
 rtl/dmem_line_array.sv | 29 ++
 rtl/dmem_line_responder.sv | 121 ++++++++++++
 tb/tb_dmem_line_responder.sv | 329 ++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/dmem_pkg.sv
// Shared definitions for the dcache line-transfer path: line geometry,
// responder FSM state encoding and the byte-address to line-index helper.
package dmem_pkg;

  localparam int unsigned LINE_W   = 256;
  localparam int unsigned OFFSET_W = 5;

  typedef logic [LINE_W-1:0] line_t;

  // Two-bit state type; the encodings are kept as plain constants so older
  // blocks that compare against raw codes keep working.
  typedef logic [1:0] state_t;
  localparam state_t ST_IDLE = 2'd0;
  localparam state_t ST_WAIT = 2'd1;
  localparam state_t ST_ACK  = 2'd2;

  // Strip the byte offset; callers truncate to their own index width, which
  // makes addresses beyond the array depth wrap.
  function automatic logic [31-OFFSET_W:0] line_idx(input logic [31:0] addr);
    line_idx = addr[31:OFFSET_W];
  endfunction

endpackage

// File: rtl/dmem_line_responder_if.sv
// Line-transfer bus between the dcache miss/writeback engine (master) and
// the line memory (slave). One request is outstanding at a time.
interface dmem_line_responder_if;
  import dmem_pkg::*;

  logic [31:0] addr_i;
  line_t       data_i;
  logic        enable_i;
  logic        write_i;
  logic        ack_o;
  line_t       data_o;

  modport master (
    output addr_i, data_i, enable_i, write_i,
    input  ack_o, data_o
  );

  modport slave (
    input  addr_i, data_i, enable_i, write_i,
    output ack_o, data_o
  );

endinterface

// File: rtl/dmem_line_array.sv
// Single-port line storage with a registered read port. Kept free of reset
// and of any bypass so it can be swapped for an SRAM macro.
module dmem_line_array #(
  parameter int unsigned IDX_W  = 9,
  parameter int unsigned DATA_W = 256
) (
  input  logic              clk_i,
  input  logic              we_i,
  input  logic              re_i,
  input  logic [IDX_W-1:0]  idx_i,
  input  logic [DATA_W-1:0] wdata_i,
  output logic [DATA_W-1:0] rdata_o
);

  logic [DATA_W-1:0] mem_r [0:(2**IDX_W)-1];
  logic [DATA_W-1:0] rdata_r;

  // One access per edge: a write, or a read into the output register.
  always_ff @(posedge clk_i) begin
    if (we_i) begin
      mem_r[idx_i] <= wdata_i;
    end else if (re_i) begin
      rdata_r <= mem_r[idx_i];
    end
  end

  assign rdata_o = rdata_r;

endmodule

// File: rtl/dmem_line_responder.sv
// Slave end of the dcache line bus. Latches a request, waits LATENCY cycles,
// performs the line access and pulses ack_o for one cycle.
module dmem_line_responder
  import dmem_pkg::state_t, dmem_pkg::ST_IDLE, dmem_pkg::ST_WAIT,
         dmem_pkg::ST_ACK, dmem_pkg::line_idx;
#(
  parameter int unsigned LATENCY = 10,
  parameter int unsigned LINE_W  = 256,
  parameter int unsigned IDX_W   = 9
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  dmem_line_responder_if.slave  bus
);

  generate
    if (LATENCY < 1 || LATENCY > 255) begin : g_bad_latency
      $fatal(1, "dmem_line_responder: LATENCY must be in 1..255");
    end
    if (LINE_W != dmem_pkg::LINE_W) begin : g_bad_line_w
      $fatal(1, "dmem_line_responder: LINE_W must match the cache line size");
    end
  endgenerate

  localparam logic [7:0] CNT_LOAD = 8'(LATENCY - 1);

  state_t            state_r;
  logic [7:0]        cnt_r;
  logic [IDX_W-1:0]  idx_r;
  logic              write_r;
  logic [LINE_W-1:0] wdata_r;
  logic              ack_r;
  logic              rd_valid_r;

  logic [IDX_W-1:0]  req_idx_s;
  logic              complete_s;
  logic              we_s;
  logic              re_s;
  logic [LINE_W-1:0] rdata_s;

  assign req_idx_s = IDX_W'(line_idx(bus.addr_i));

  // The access happens on the edge where the wait counter has run out.
  always_comb begin
    complete_s = 1'b0;
    if ((state_r == ST_WAIT) && (cnt_r == 8'd0)) begin
      complete_s = 1'b1;
    end else begin
      complete_s = 1'b0;
    end
  end

  assign we_s = complete_s & write_r;
  assign re_s = complete_s & ~write_r;

  // Request FSM: accept in IDLE, count down in WAIT, one ack cycle in ACK.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_r    <= ST_IDLE;
      cnt_r      <= 8'd0;
      idx_r      <= '0;
      write_r    <= 1'b0;
      wdata_r    <= '0;
      ack_r      <= 1'b0;
      rd_valid_r <= 1'b0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          ack_r <= 1'b0;
          if (bus.enable_i) begin
            idx_r   <= req_idx_s;
            write_r <= bus.write_i;
            wdata_r <= bus.data_i;
            cnt_r   <= CNT_LOAD;
            state_r <= ST_WAIT;
          end else begin
            state_r <= ST_IDLE;
          end
        end
        ST_WAIT: begin
          if (cnt_r != 8'd0) begin
            cnt_r <= cnt_r - 8'd1;
          end else begin
            ack_r   <= 1'b1;
            state_r <= ST_ACK;
            if (!write_r) begin
              rd_valid_r <= 1'b1;
            end
          end
        end
        ST_ACK: begin
          ack_r   <= 1'b0;
          state_r <= ST_IDLE;
        end
        default: begin
          ack_r   <= 1'b0;
          cnt_r   <= 8'd0;
          state_r <= ST_IDLE;
        end
      endcase
    end
  end

  dmem_line_array #(
    .IDX_W  (IDX_W),
    .DATA_W (LINE_W)
  ) u_array (
    .clk_i   (clk_i),
    .we_i    (we_s),
    .re_i    (re_s),
    .idx_i   (idx_r),
    .wdata_i (wdata_r),
    .rdata_o (rdata_s)
  );

  // The array read register has no reset, so data_o shows zero until the
  // first read since reset has completed; afterwards it holds the last read.
  assign bus.ack_o  = ack_r;
  assign bus.data_o = rd_valid_r ? rdata_s : '0;

endmodule

// File: tb/tb_dmem_line_responder.sv
// Randomised bench for dmem_line_responder against a line-memory model.
module tb_dmem_line_responder;
  import dmem_pkg::*;

  localparam int LAT   = 10;
  localparam int DEPTH = 512;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  dmem_line_responder_if bus();
  dmem_line_responder_if bus1();

  dmem_line_responder #(.LATENCY(LAT), .LINE_W(256), .IDX_W(9)) u_dut (
    .clk_i (clk), .rst_i (rst_n), .bus (bus)
  );

  dmem_line_responder #(.LATENCY(1), .LINE_W(256), .IDX_W(9)) u_dut1 (
    .clk_i (clk), .rst_i (rst_n), .bus (bus1)
  );

  int    tests_run    = 0;
  int    tests_failed = 0;
  line_t mem_m  [DEPTH];
  line_t mem1_m [DEPTH];
  line_t last_rd  = '0;
  line_t last_rd1 = '0;

  function automatic line_t rand_line();
    line_t v;
    for (int i = 0; i < 8; i++) v[i*32 +: 32] = $urandom;
    return v;
  endfunction

  function automatic int idx_of(input logic [31:0] a);
    return int'((a / 32'd32) % 32'd512);
  endfunction

  // One request on the LATENCY=10 responder, with optional disturbances.
  task automatic run_req(input bit wr, input logic [31:0] addr, input line_t wdata,
                         input int disturb_k, input int drop_k, input string tag);
    int lat;
    int idx;
    idx = idx_of(addr);
    @(negedge clk);
    bus.enable_i = 1'b1; bus.write_i = wr; bus.addr_i = addr; bus.data_i = wdata;
    @(posedge clk);
    lat = -1;
    for (int k = 0; k <= LAT + 8; k++) begin
      @(negedge clk);
      if (bus.ack_o === 1'b1) begin
        lat = k;
        break;
      end
      if (k == disturb_k) begin
        bus.addr_i = $urandom; bus.data_i = rand_line(); bus.write_i = ~wr;
      end
      if (k == drop_k) bus.enable_i = 1'b0;
    end
    if (wr) mem_m[idx] = wdata;
    else last_rd = mem_m[idx];
    tests_run++;
    if (lat !== LAT) begin
      tests_failed++;
      $display("FAIL %s latency: got %0d want %0d", tag, lat, LAT);
    end
    tests_run++;
    if (bus.data_o !== last_rd) begin
      tests_failed++;
      $display("FAIL %s data_o in ack cycle: got %h want %h", tag, bus.data_o, last_rd);
    end
    bus.enable_i = 1'b0;
    @(negedge clk);
    tests_run++;
    if (bus.ack_o !== 1'b0 || bus.data_o !== last_rd) begin
      tests_failed++;
      $display("FAIL %s after ack: ack=%b data_o=%h want ack=0 data_o=%h",
               tag, bus.ack_o, bus.data_o, last_rd);
    end
  endtask

  // One request on the LATENCY=1 responder.
  task automatic run_req1(input bit wr, input logic [31:0] addr, input line_t wdata);
    int lat;
    @(negedge clk);
    bus1.enable_i = 1'b1; bus1.write_i = wr; bus1.addr_i = addr; bus1.data_i = wdata;
    @(posedge clk);
    lat = -1;
    for (int k = 0; k <= 8; k++) begin
      @(negedge clk);
      if (bus1.ack_o === 1'b1) begin
        lat = k;
        break;
      end
    end
    if (wr) mem1_m[idx_of(addr)] = wdata;
    else last_rd1 = mem1_m[idx_of(addr)];
    tests_run++;
    if (lat !== 1 || bus1.data_o !== last_rd1) begin
      tests_failed++;
      $display("FAIL lat1 req: lat=%0d data_o=%h want lat=1 data_o=%h", lat, bus1.data_o, last_rd1);
    end
    bus1.enable_i = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    tests_run++;
    if (bus.ack_o !== 1'b0 || bus.data_o !== '0 || bus1.ack_o !== 1'b0 || bus1.data_o !== '0) begin
      tests_failed++;
      $display("FAIL reset outputs: ack=%b/%b data_o nonzero or X", bus.ack_o, bus1.ack_o);
    end
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    tests_run++;
    if (bus.ack_o !== 1'b0 || bus.data_o !== '0) begin
      tests_failed++;
      $display("FAIL reset release: ack=%b data_o=%h want 0", bus.ack_o, bus.data_o);
    end
  endtask

  task automatic test_preload();
    line_t d;
    for (int i = 0; i < DEPTH; i++) begin
      d = (i == 3) ? {32{8'hA5}} : rand_line();
      run_req(1'b1, {18'($urandom), 9'(i), 5'($urandom)}, d, -1, -1, "preload");
    end
    tests_run++;
    if (bus.data_o !== '0) begin
      tests_failed++;
      $display("FAIL writes disturb data_o: got %h want 0", bus.data_o);
    end
  endtask

  task automatic test_read_latency();
    run_req(1'b0, 32'h0000_0060, '0, -1, -1, "read_line3");
    tests_run++;
    if (last_rd !== {32{8'hA5}} || bus.data_o !== {32{8'hA5}}) begin
      tests_failed++;
      $display("FAIL read_line3 value: got %h want all A5", bus.data_o);
    end
  endtask

  task automatic test_write_read();
    run_req(1'b1, 32'h0000_01E0, {4{64'h0123_4567_89AB_CDEF}}, -1, -1, "wr_1e0");
    run_req(1'b0, 32'h0000_01E0, '0, -1, -1, "rd_1e0");
    tests_run++;
    if (bus.data_o !== {4{64'h0123_4567_89AB_CDEF}}) begin
      tests_failed++;
      $display("FAIL rd_1e0 value: got %h want 0123..CDEF", bus.data_o);
    end
    run_req(1'b0, 32'h0000_0000, '0, -1, -1, "rd_line0");
  endtask

  task automatic test_back_to_back();
    line_t wl;
    int    lat;
    int    gap;
    bit    seen;
    wl = rand_line();
    @(negedge clk);
    bus.enable_i = 1'b1; bus.write_i = 1'b1; bus.addr_i = 32'h0000_0400; bus.data_i = wl;
    @(posedge clk);
    lat = -1;
    for (int k = 0; k <= LAT + 8; k++) begin
      @(negedge clk);
      if (bus.ack_o === 1'b1) begin
        lat = k;
        break;
      end
    end
    mem_m[32] = wl;
    tests_run++;
    if (lat !== LAT || bus.data_o !== last_rd) begin
      tests_failed++;
      $display("FAIL b2b writeback: lat=%0d data_o=%h want lat=%0d data_o=%h", lat, bus.data_o, LAT, last_rd);
    end
    // stale values shown during the ack cycle must be ignored
    bus.write_i = 1'b1; bus.addr_i = 32'h0000_00A0; bus.data_i = rand_line();
    @(negedge clk);
    gap = 1;
    tests_run++;
    if (bus.ack_o !== 1'b0 || bus.data_o !== last_rd) begin
      tests_failed++;
      $display("FAIL b2b after writeback ack: ack=%b data_o=%h want 0/%h", bus.ack_o, bus.data_o, last_rd);
    end
    bus.write_i = 1'b0; bus.addr_i = 32'h0000_0800;
    seen = 1'b0;
    while (gap < LAT + 12 && !seen) begin
      @(negedge clk);
      gap++;
      if (bus.ack_o === 1'b1) seen = 1'b1;
    end
    last_rd = mem_m[64];
    tests_run++;
    if (!seen || gap !== LAT + 2) begin
      tests_failed++;
      $display("FAIL b2b refill spacing: seen=%b gap=%0d want %0d", seen, gap, LAT + 2);
    end
    tests_run++;
    if (bus.data_o !== last_rd) begin
      tests_failed++;
      $display("FAIL b2b refill data: got %h want %h", bus.data_o, last_rd);
    end
    bus.enable_i = 1'b0;
    @(negedge clk);
    tests_run++;
    if (bus.ack_o !== 1'b0 || bus.data_o !== last_rd) begin
      tests_failed++;
      $display("FAIL b2b refill hold: ack=%b data_o=%h want 0/%h", bus.ack_o, bus.data_o, last_rd);
    end
    run_req(1'b0, 32'h0000_00A0, '0, -1, -1, "b2b_stale_line5");
  endtask

  task automatic test_addr_wrap();
    line_t d;
    d = rand_line();
    run_req(1'b1, 32'h0000_4020, d, -1, -1, "wrap_wr");
    run_req(1'b0, 32'h0000_0020, '0, -1, -1, "wrap_rd");
    tests_run++;
    if (bus.data_o !== d) begin
      tests_failed++;
      $display("FAIL wrap value: got %h want %h", bus.data_o, d);
    end
  endtask

  task automatic test_disturb();
    run_req(1'b1, 32'h0000_00E0, rand_line(), 1, 4, "disturb_wr");
    run_req(1'b0, 32'h0000_00E0, '0, -1, -1, "disturb_rd7");
    run_req(1'b0, 32'h0000_0100, '0, 2, -1, "disturb_rdchg");
    run_req(1'b0, 32'h0000_00E0, '0, -1, 4, "drop_rd");
  endtask

  task automatic test_random();
    int dk;
    int pk;
    for (int n = 0; n < 40; n++) begin
      dk = ($urandom_range(0, 1) == 1) ? int'($urandom_range(0, LAT - 1)) : -1;
      pk = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, LAT - 1)) : -1;
      run_req(1'($urandom_range(0, 1)), $urandom, rand_line(), dk, pk, "random");
    end
  endtask

  task automatic test_reset_mid();
    line_t old9;
    run_req(1'b0, 32'h0000_0040, '0, -1, -1, "pre_reset_rd");
    old9 = mem_m[9];
    @(negedge clk);
    bus.enable_i = 1'b1; bus.write_i = 1'b1; bus.addr_i = 32'h0000_0120; bus.data_i = ~old9;
    @(posedge clk);
    repeat (4) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    tests_run++;
    if (bus.ack_o !== 1'b0 || bus.data_o !== '0) begin
      tests_failed++;
      $display("FAIL reset mid-request: ack=%b data_o=%h want 0", bus.ack_o, bus.data_o);
    end
    bus.enable_i = 1'b0;
    last_rd = '0; last_rd1 = '0;
    repeat (LAT) @(negedge clk);
    tests_run++;
    if (bus.ack_o !== 1'b0) begin
      tests_failed++;
      $display("FAIL ack during reset: got %b want 0", bus.ack_o);
    end
    rst_n = 1'b1;
    @(negedge clk);
    run_req(1'b0, 32'h0000_0120, '0, -1, -1, "aborted_line9");
  endtask

  task automatic test_lat1_back_to_back();
    logic [31:0] a [6];
    int n;
    int j;
    int prev;
    int want;
    for (int i = 0; i < 8; i++) run_req1(1'b1, 32'(i) << 5, rand_line());
    for (int i = 0; i < 6; i++) a[i] = 32'($urandom_range(0, 7)) << 5;
    @(negedge clk);
    bus1.enable_i = 1'b1; bus1.write_i = 1'b0; bus1.addr_i = a[0];
    n = 0; j = 0; prev = 0;
    while (j < 6 && n < 60) begin
      @(negedge clk);
      n++;
      if (bus1.ack_o === 1'b1) begin
        want = (j == 0) ? 2 : prev + 3;
        tests_run++;
        if (n !== want || bus1.data_o !== mem1_m[idx_of(a[j])]) begin
          tests_failed++;
          $display("FAIL lat1 b2b ack %0d: cycle=%0d want %0d data_o=%h want %h",
                   j, n, want, bus1.data_o, mem1_m[idx_of(a[j])]);
        end
        prev = n;
        j++;
        if (j < 6) bus1.addr_i = a[j];
        else bus1.enable_i = 1'b0;
      end
    end
    bus1.enable_i = 1'b0;
    tests_run++;
    if (j !== 6) begin
      tests_failed++;
      $display("FAIL lat1 b2b timeout: got %0d acks want 6", j);
    end
  endtask

  initial begin
    bus.enable_i  = 1'b0; bus.write_i  = 1'b0; bus.addr_i  = '0; bus.data_i  = '0;
    bus1.enable_i = 1'b0; bus1.write_i = 1'b0; bus1.addr_i = '0; bus1.data_i = '0;
    test_reset();
    test_preload();
    test_read_latency();
    test_write_read();
    test_back_to_back();
    test_addr_wrap();
    test_disturb();
    test_random();
    test_reset_mid();
    test_lat1_back_to_back();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
